// File: rtl/board_port_sched_pkg.sv
// Board geometry, cell codes and scheduler state shared by the
// board port B scheduler and its arbiter.
package board_port_sched_pkg;

    localparam int BOARD_W = 32;
    localparam int BOARD_H = 16;
    localparam int CELL_W  = 4;
    localparam int X_W     = 5;
    localparam int Y_W     = 4;
    localparam int CNT_W   = X_W + Y_W;

    typedef enum logic [CELL_W-1:0] {
        CELL_EMPTY = 4'h0,
        CELL_SNAKE = 4'h1,
        CELL_HEAD  = 4'h2,
        CELL_FOOD  = 4'h3,
        CELL_WALL  = 4'h4
    } cell_t;

    typedef enum logic {
        ST_CLEAR,
        ST_SERVE
    } sched_state_t;

endpackage

// File: rtl/board_port_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours whichever
// requester was not granted last.
module rr_arb2
    import board_port_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic       favour_r1;
    logic [1:0] elig;

    // A requester granted this cycle still shows its old req.
    assign elig = req & ~mask;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = favour_r1 ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_r1 <= 1'b0;
        end else if (|grant) begin
            favour_r1 <= grant[0];
        end
    end

endmodule

// File: rtl/board_port_sched.sv
// Board RAM port B owner: full-board clear after reset or on
// request, then round-robin cell access for two requesters.
module board_port_sched
    import board_port_sched_pkg::*;
#(
    parameter int                WIDTH       = BOARD_W,
    parameter int                HEIGHT      = BOARD_H,
    parameter int                DATA_W      = CELL_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(CELL_EMPTY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [X_W-1:0]    r0_x,
    input  logic [Y_W-1:0]    r0_y,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [X_W-1:0]    r1_x,
    input  logic [Y_W-1:0]    r1_y,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [X_W-1:0]    ram_x,
    output logic [Y_W-1:0]    ram_y,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] LAST_CELL =
        CNT_W'(WIDTH * HEIGHT - 1);

    sched_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             clr_last;
    logic [1:0]       gnt_q;
    logic [1:0]       rvalid_q;
    logic [1:0]       grant;
    logic             arb_en;

    // A clear request beats any decision pending on the same edge.
    assign arb_en = (state == ST_SERVE) && !clear_start;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({r1_req, r0_req}),
        .mask  (gnt_q),
        .grant (grant)
    );

    assign r0_gnt    = gnt_q[0];
    assign r1_gnt    = gnt_q[1];
    assign r0_rvalid = rvalid_q[0];
    assign r1_rvalid = rvalid_q[1];
    assign rdata     = (|rvalid_q) ? ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            clr_last   <= 1'b0;
            busy       <= 1'b1;
            clear_done <= 1'b0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            ram_x      <= '0;
            ram_y      <= '0;
            ram_read   <= 1'b0;
            ram_write  <= 1'b0;
            ram_wdata  <= '0;
        end else begin
            gnt_q      <= 2'b00;
            clear_done <= 1'b0;
            ram_read   <= 1'b0;
            ram_write  <= 1'b0;
            // Reads in flight complete regardless of a clear start.
            rvalid_q   <= gnt_q & {2{ram_read}};
            if (clear_start) begin
                state          <= ST_CLEAR;
                busy           <= 1'b1;
                ram_write      <= 1'b1;
                {ram_y, ram_x} <= '0;
                ram_wdata      <= CLEAR_VALUE;
                cnt            <= CNT_W'(1);
                clr_last       <= 1'b0;
            end else begin
                unique case (state)
                    ST_CLEAR: begin
                        if (clr_last) begin
                            state      <= ST_SERVE;
                            busy       <= 1'b0;
                            clear_done <= 1'b1;
                            clr_last   <= 1'b0;
                            cnt        <= '0;
                        end else begin
                            ram_write      <= 1'b1;
                            {ram_y, ram_x} <= cnt;
                            ram_wdata      <= CLEAR_VALUE;
                            cnt            <= cnt + 1'b1;
                            clr_last       <= (cnt == LAST_CELL);
                        end
                    end
                    ST_SERVE: begin
                        gnt_q <= grant;
                        unique case (1'b1)
                            grant[0]: begin
                                ram_x     <= r0_x;
                                ram_y     <= r0_y;
                                ram_wdata <= r0_wdata;
                                ram_read  <= ~r0_we;
                                ram_write <= r0_we;
                            end
                            grant[1]: begin
                                ram_x     <= r1_x;
                                ram_y     <= r1_y;
                                ram_wdata <= r1_wdata;
                                ram_read  <= ~r1_we;
                                ram_write <= r1_we;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_port_sched.sv
// Randomized self-checking bench for board_port_sched with a RAM
// model and a grant-order/board-content reference model.
module tb_board_port_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_start = 1'b0;
    logic       busy, clear_done;
    logic       r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [4:0] r0_x = 0, r1_x = 0;
    logic [3:0] r0_y = 0, r1_y = 0;
    logic [3:0] r0_wdata = 0, r1_wdata = 0;
    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [3:0] rdata;
    logic [4:0] ram_x;
    logic [3:0] ram_y;
    logic       ram_read, ram_write;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata = 4'h0;
    logic       preload = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    logic [3:0] ram [512];
    logic [3:0] mdl [512];
    int         mdl_last;

    logic [4:0] opx  [2][8];
    logic [3:0] opy  [2][8];
    logic       opwe [2][8];
    logic [3:0] opd  [2][8];
    int         cnt_ [2];
    int         idx_ [2];

    always #5 clk = ~clk;

    board_port_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .r0_req      (r0_req),
        .r0_we       (r0_we),
        .r0_x        (r0_x),
        .r0_y        (r0_y),
        .r0_wdata    (r0_wdata),
        .r0_gnt      (r0_gnt),
        .r0_rvalid   (r0_rvalid),
        .r1_req      (r1_req),
        .r1_we       (r1_we),
        .r1_x        (r1_x),
        .r1_y        (r1_y),
        .r1_wdata    (r1_wdata),
        .r1_gnt      (r1_gnt),
        .r1_rvalid   (r1_rvalid),
        .rdata       (rdata),
        .ram_x       (ram_x),
        .ram_y       (ram_y),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Board RAM port B: synchronous write, 1-cycle read
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) ram[i] <= 4'($urandom_range(1, 15));
        end else begin
            if (ram_write) ram[{ram_y, ram_x}] <= ram_wdata;
            if (ram_read) ram_rdata <= ram[{ram_y, ram_x}];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 512; i++) mdl[i] = 4'h0;
    endtask

    task automatic drive_reqs();
        r0_req = (idx_[0] < cnt_[0]);
        r1_req = (idx_[1] < cnt_[1]);
        if (r0_req) begin
            r0_we = opwe[0][idx_[0]]; r0_x = opx[0][idx_[0]];
            r0_y = opy[0][idx_[0]]; r0_wdata = opd[0][idx_[0]];
        end
        if (r1_req) begin
            r1_we = opwe[1][idx_[1]]; r1_x = opx[1][idx_[1]];
            r1_y = opy[1][idx_[1]]; r1_wdata = opd[1][idx_[1]];
        end
    endtask

    // Observes a clear pass until clear_done or the cycle budget expires.
    task automatic watch_clear(input int idx0, output int nbusy, output int nwr,
                               output int nerr, output int ngnt, output int nrv,
                               output bit done);
        int idx;
        idx = idx0;
        nbusy = 0; nwr = 0; nerr = 0; ngnt = 0; nrv = 0; done = 0;
        for (int c = 0; c < 700 && !done; c++) begin
            step();
            if (busy) nbusy++;
            if (ram_write) begin
                if ({ram_y, ram_x} != 9'(idx) || ram_wdata != 4'h0) nerr++;
                idx++;
                nwr++;
            end
            if (r0_gnt || r1_gnt) ngnt++;
            if (r0_rvalid || r1_rvalid) nrv++;
            if (clear_done) done = 1;
        end
    endtask

    task automatic test_reset();
        preload = 1'b1;
        step();
        preload = 1'b0;
        step();
        n_chk++;
        if ({busy, clear_done, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid,
             ram_read, ram_write} !== 8'b1000_0000)
            $display("FAIL reset_ctrl got %b want 10000000",
                     {busy, clear_done, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid,
                      ram_read, ram_write});
        else n_pass++;
        n_chk++;
        if ({rdata, ram_x, ram_y, ram_wdata} !== 17'h0)
            $display("FAIL reset_data got %h want 0", {rdata, ram_x, ram_y, ram_wdata});
        else n_pass++;
    endtask

    task automatic test_clear_after_reset();
        int nb, nw, ne, ng, nv, nz;
        bit dn;
        rst_n = 1'b1;
        mdl_last = 1;
        watch_clear(0, nb, nw, ne, ng, nv, dn);
        mdl_clear();
        n_chk++;
        if (nb != 512) $display("FAIL clr_busy_cycles got %0d want 512", nb); else n_pass++;
        n_chk++;
        if (nw != 512 || ne != 0)
            $display("FAIL clr_writes got %0d (bad %0d) want 512 (bad 0)", nw, ne);
        else n_pass++;
        n_chk++;
        if (!(dn && busy === 1'b0))
            $display("FAIL clr_done got done=%0d busy=%b want 1/0", dn, busy);
        else n_pass++;
        n_chk++;
        if (ng != 0) $display("FAIL clr_no_gnt got %0d want 0", ng); else n_pass++;
        step();
        n_chk++;
        if (clear_done !== 1'b0) $display("FAIL clr_done_once got 1 want 0"); else n_pass++;
        nz = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== 4'h0) nz++;
        n_chk++;
        if (nz != 0) $display("FAIL clr_readback got %0d nonzero want 0", nz); else n_pass++;
    endtask

    task automatic test_write_read();
        r0_req = 1; r0_we = 1; r0_x = 5; r0_y = 3; r0_wdata = 4'h2;
        step();
        n_chk++;
        if ({r0_gnt, r1_gnt, ram_write, ram_read, ram_x, ram_y, ram_wdata} !==
            {4'b1010, 5'd5, 4'd3, 4'h2})
            $display("FAIL wr_gnt got %b %b %b %b %0d %0d %h want 1 0 1 0 5 3 2",
                     r0_gnt, r1_gnt, ram_write, ram_read, ram_x, ram_y, ram_wdata);
        else n_pass++;
        mdl[3 * 32 + 5] = 4'h2;
        mdl_last = 0;
        r0_req = 0;
        step();
        n_chk++;
        if ({r0_gnt, ram_write, ram_read} !== 3'b000)
            $display("FAIL idle got %b want 000", {r0_gnt, ram_write, ram_read});
        else n_pass++;
        r0_req = 1; r0_we = 0;
        step();
        n_chk++;
        if ({r0_gnt, ram_read, ram_write, ram_x, ram_y} !== {3'b110, 5'd5, 4'd3})
            $display("FAIL rd_gnt got %b%b%b %0d %0d want 110 5 3",
                     r0_gnt, ram_read, ram_write, ram_x, ram_y);
        else n_pass++;
        mdl_last = 0;
        r0_req = 0;
        step();
        n_chk++;
        if ({r0_rvalid, r1_rvalid, rdata} !== {2'b10, mdl[3 * 32 + 5]})
            $display("FAIL rd_data got %b%b %h want 10 %h", r0_rvalid, r1_rvalid,
                     rdata, mdl[3 * 32 + 5]);
        else n_pass++;
        step();
        n_chk++;
        if (r0_rvalid !== 1'b0) $display("FAIL rd_once got 1 want 0"); else n_pass++;
    endtask

    task automatic test_traffic(input string name, input int n0, input int n1);
        int prev, pend, ew, ngr, a, k;
        logic [3:0] pend_d;
        logic [1:0] eg, erv;
        bit e0, e1;
        cnt_[0] = n0; cnt_[1] = n1; idx_[0] = 0; idx_[1] = 0;
        for (int w = 0; w < 2; w++) begin
            for (int j = 0; j < 8; j++) begin
                opx[w][j] = 5'($urandom_range(0, 3));
                opy[w][j] = 4'($urandom_range(0, 1));
                opwe[w][j] = 1'($urandom_range(0, 1));
                opd[w][j] = 4'($urandom);
            end
        end
        prev = -1; pend = -1; ngr = 0; pend_d = 4'h0;
        drive_reqs();
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (idx_[0] >= cnt_[0] && idx_[1] >= cnt_[1] && pend < 0) break;
            e0 = r0_req && prev != 0;
            e1 = r1_req && prev != 1;
            if (e0 && e1) ew = (mdl_last == 0) ? 1 : 0;
            else if (e0) ew = 0;
            else if (e1) ew = 1;
            else ew = -1;
            eg = (ew < 0) ? 2'b00 : (ew == 0 ? 2'b01 : 2'b10);
            erv = (pend < 0) ? 2'b00 : (pend == 0 ? 2'b01 : 2'b10);
            step();
            n_chk++;
            if ({r1_gnt, r0_gnt} !== eg)
                $display("FAIL %s_gnt cyc %0d got %b want %b", name, cyc, {r1_gnt, r0_gnt}, eg);
            else n_pass++;
            n_chk++;
            if ({r1_rvalid, r0_rvalid} !== erv || (pend >= 0 && rdata !== pend_d))
                $display("FAIL %s_rvalid cyc %0d got %b %h want %b %h", name, cyc,
                         {r1_rvalid, r0_rvalid}, rdata, erv, pend_d);
            else n_pass++;
            pend = -1;
            if (ew >= 0) begin
                k = idx_[ew];
                a = {opy[ew][k], opx[ew][k]};
                n_chk++;
                if (ram_x !== opx[ew][k] || ram_y !== opy[ew][k] ||
                    ram_write !== opwe[ew][k] || ram_read !== !opwe[ew][k] ||
                    (opwe[ew][k] && ram_wdata !== opd[ew][k]))
                    $display("FAIL %s_ram cyc %0d got %0d,%0d w%b r%b %h want %0d,%0d w%b %h",
                             name, cyc, ram_x, ram_y, ram_write, ram_read, ram_wdata,
                             opx[ew][k], opy[ew][k], opwe[ew][k], opd[ew][k]);
                else n_pass++;
                if (opwe[ew][k]) mdl[a] = opd[ew][k];
                else begin
                    pend = ew;
                    pend_d = mdl[a];
                end
                mdl_last = ew;
                idx_[ew]++;
                ngr++;
            end
            prev = ew;
            drive_reqs();
        end
        r0_req = 0; r1_req = 0;
        n_chk++;
        if (ngr != n0 + n1) $display("FAIL %s_count got %0d want %0d", name, ngr, n0 + n1);
        else n_pass++;
        step();
        n_chk++;
        if ({r0_gnt, r1_gnt, ram_read, ram_write} !== 4'b0000)
            $display("FAIL %s_idle got %b want 0000", name, {r0_gnt, r1_gnt, ram_read, ram_write});
        else n_pass++;
    endtask

    task automatic test_clear_restart();
        int nb, nw, ne, ng, nv, pre_done;
        bit dn;
        logic [4:0] rx;
        logic [3:0] ry;
        rx = 5'($urandom_range(0, 31));
        ry = 4'($urandom_range(0, 15));
        pre_done = 0;
        r0_req = 1; r0_we = 0; r0_x = 5; r0_y = 3;
        step();
        n_chk++;
        if (r0_gnt !== 1'b1) $display("FAIL rst_pre_gnt got 0 want 1"); else n_pass++;
        mdl_last = 0;
        r0_req = 0; clear_start = 1;
        r1_req = 1; r1_we = 0; r1_x = 1; r1_y = 1;
        step();
        clear_start = 0; r1_req = 0;
        n_chk++;
        if ({r0_rvalid, rdata} !== {1'b1, mdl[3 * 32 + 5]})
            $display("FAIL inflight_rvalid got %b %h want 1 %h", r0_rvalid, rdata, mdl[3 * 32 + 5]);
        else n_pass++;
        n_chk++;
        if (r1_gnt !== 1'b0) $display("FAIL clear_wins got 1 want 0"); else n_pass++;
        n_chk++;
        if ({busy, ram_write, ram_y, ram_x} !== {2'b11, 9'd0})
            $display("FAIL start_cell got %b%b %0d want 11 0", busy, ram_write, {ram_y, ram_x});
        else n_pass++;
        for (int c = 0; c < 300; c++) begin
            if (ram_write && {ram_y, ram_x} == 9'd200) break;
            step();
            if (clear_done) pre_done++;
        end
        n_chk++;
        if (!(ram_write && {ram_y, ram_x} == 9'd200))
            $display("FAIL reach_200 got %0d want 200", {ram_y, ram_x});
        else n_pass++;
        clear_start = 1;
        r0_req = 1; r0_we = 0; r0_x = rx; r0_y = ry;
        step();
        clear_start = 0;
        n_chk++;
        if ({busy, ram_write, r0_gnt, ram_y, ram_x} !== {3'b110, 9'd0})
            $display("FAIL restart_cell got %b%b%b %0d want 110 0", busy, ram_write,
                     r0_gnt, {ram_y, ram_x});
        else n_pass++;
        watch_clear(1, nb, nw, ne, ng, nv, dn);
        mdl_clear();
        n_chk++;
        if (nb != 511 || nw != 511 || ne != 0)
            $display("FAIL restart_len got busy %0d wr %0d bad %0d want 511 511 0", nb, nw, ne);
        else n_pass++;
        n_chk++;
        if (!(dn && busy === 1'b0) || pre_done != 0)
            $display("FAIL restart_done got done=%0d pre=%0d want 1 0", dn, pre_done);
        else n_pass++;
        n_chk++;
        if (ng != 0) $display("FAIL restart_no_gnt got %0d want 0", ng); else n_pass++;
        step();
        n_chk++;
        if ({r0_gnt, ram_read, clear_done, ram_x, ram_y} !== {3'b110, rx, ry})
            $display("FAIL post_clear_gnt got %b%b%b %0d,%0d want 110 %0d,%0d",
                     r0_gnt, ram_read, clear_done, ram_x, ram_y, rx, ry);
        else n_pass++;
        mdl_last = 0;
        r0_req = 0;
        step();
        n_chk++;
        if ({r0_rvalid, rdata} !== {1'b1, mdl[{ry, rx}]})
            $display("FAIL post_clear_rd got %b %h want 1 %h", r0_rvalid, rdata, mdl[{ry, rx}]);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int nb, nw, ne, ng, nv;
        bit dn;
        r0_req = 1; r0_we = 0;
        r0_x = 5'($urandom_range(0, 31)); r0_y = 4'($urandom_range(0, 15));
        step();
        n_chk++;
        if ({r0_gnt, ram_read} !== 2'b11) $display("FAIL mid_gnt got %b want 11", {r0_gnt, ram_read});
        else n_pass++;
        r0_req = 0;
        rst_n = 0;
        #1;
        n_chk++;
        if ({busy, clear_done, r0_gnt, r0_rvalid, ram_read, ram_write, rdata} !== {6'b100000, 4'h0})
            $display("FAIL async_reset got %b %h want 100000 0",
                     {busy, clear_done, r0_gnt, r0_rvalid, ram_read, ram_write}, rdata);
        else n_pass++;
        step();
        rst_n = 1;
        mdl_last = 1;
        watch_clear(0, nb, nw, ne, ng, nv, dn);
        mdl_clear();
        n_chk++;
        if (nv != 0) $display("FAIL stale_rvalid got %0d want 0", nv); else n_pass++;
        n_chk++;
        if (nb != 512 || nw != 512 || ne != 0 || !dn)
            $display("FAIL reclear got busy %0d wr %0d bad %0d done %0d want 512 512 0 1",
                     nb, nw, ne, dn);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clear_after_reset();
        test_write_read();
        test_traffic("both", 8, 8);
        test_traffic("single_r1", 0, 4);
        test_traffic("mixed", $urandom_range(1, 8), $urandom_range(1, 8));
        test_clear_restart();
        test_reset_midflight();
        test_traffic("post_reset", 2, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
